// File: rtl/run_sequencer_pkg.sv
// Shared definitions for the run sequencer: FSM state encoding and default sizing.
package run_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    HALT  = 3'd3,
    ERROR = 3'd4
  } state_t;

  localparam int DEF_AW      = 5;
  localparam int DEF_MEM_LAT = 1;

  // Counter widths cover the legal ranges of MEM_LAT (1..7) and TIMEOUT (2..255).
  localparam int LAT_W  = 3;
  localparam int WDOG_W = 8;

endpackage

// File: rtl/run_sequencer_seq_timer.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module run_sequencer_seq_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/run_sequencer.sv
// Instruction sequencer: presents Addr, waits out the memory latency, holds Run until Done,
// then advances; includes a watchdog that traps a processor that never completes.
module run_sequencer
  import run_sequencer_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int MEM_LAT  = DEF_MEM_LAT,
  parameter int END_ADDR = 31,
  parameter int WRAP     = 0,
  parameter int TIMEOUT  = 16,
  parameter int CW       = 16
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Go,
  input  logic          Single,
  input  logic          Stop,
  input  logic          Done,
  output logic [AW-1:0] Addr,
  output logic          Run,
  output logic          Busy,
  output logic          Halted,
  output logic          Err,
  output logic [CW-1:0] InstCount
);

  localparam logic [AW-1:0]     END_A  = AW'(END_ADDR);
  localparam logic [LAT_W-1:0]  LAT_V  = LAT_W'(MEM_LAT);
  localparam logic [WDOG_W-1:0] WDOG_V = WDOG_W'(TIMEOUT - 1);

  state_t        state;
  state_t        next_state;
  logic [AW-1:0] next_addr;
  logic [CW-1:0] next_count;
  logic          lat_load;
  logic          lat_zero;
  logic          wdog_load;
  logic          wdog_zero;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= IDLE;
      Addr      <= '0;
      InstCount <= '0;
      Run       <= 1'b0;
      Busy      <= 1'b0;
      Halted    <= 1'b0;
      Err       <= 1'b0;
    end else begin
      state     <= next_state;
      Addr      <= next_addr;
      InstCount <= next_count;
      Run       <= (next_state == ISSUE);
      Busy      <= (next_state == FETCH) || (next_state == ISSUE);
      Halted    <= (next_state == HALT);
      Err       <= (next_state == ERROR);
    end
  end

  always_comb begin
    next_state = state;
    next_addr  = Addr;
    next_count = InstCount;
    lat_load   = 1'b0;
    wdog_load  = 1'b0;
    case (state)
      IDLE: begin
        if (Go) next_state = FETCH;
      end
      FETCH: begin
        if (lat_zero) next_state = ISSUE;
      end
      ISSUE: begin
        // Done takes priority over a watchdog expiry on the same edge.
        if (Done) begin
          if (InstCount != '1) next_count = InstCount + CW'(1);
          if (Addr != END_A) begin
            next_addr = Addr + AW'(1);
          end else if (WRAP != 0) begin
            next_addr = '0;
          end
          if ((Addr == END_A) && (WRAP == 0)) begin
            next_state = HALT;
          end else if (Single || Stop) begin
            next_state = IDLE;
          end else begin
            next_state = FETCH;
          end
        end else if (wdog_zero) begin
          next_state = ERROR;
        end
      end
      HALT, ERROR: begin
        if (Go) begin
          next_state = IDLE;
          next_addr  = '0;
        end
      end
      default: next_state = IDLE;
    endcase
    lat_load  = (next_state == FETCH) && (state != FETCH);
    wdog_load = (next_state == ISSUE) && (state != ISSUE);
  end

  // FETCH lasts MEM_LAT+1 cycles: load MEM_LAT, count down, leave when zero is seen.
  run_sequencer_seq_timer #(.W(LAT_W)) u_lat (
    .clk      (Clock),
    .rst_n    (Resetn),
    .load     (lat_load),
    .en       (state == FETCH),
    .load_val (LAT_V),
    .zero     (lat_zero)
  );

  run_sequencer_seq_timer #(.W(WDOG_W)) u_wdog (
    .clk      (Clock),
    .rst_n    (Resetn),
    .load     (wdog_load),
    .en       (state == ISSUE),
    .load_val (WDOG_V),
    .zero     (wdog_zero)
  );

endmodule

// File: tb/tb_run_sequencer.sv
// Randomized bench for run_sequencer: two configurations checked every cycle against a
// transaction-level reference model, plus an asynchronous reset taken mid-instruction.
module tb_run_sequencer;

  localparam int AW      = 5;
  localparam int TIMEOUT = 16;

  localparam int M_WAIT  = 0;
  localparam int M_FETCH = 1;
  localparam int M_EXEC  = 2;
  localparam int M_HALT  = 3;
  localparam int M_FAULT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          go, single, stop;
  logic          done0, done1;
  logic [AW-1:0] addr0, addr1;
  logic          run0, run1, busy0, busy1, halted0, halted1, err0, err1;
  logic [15:0]   cnt0;
  logic [2:0]    cnt1;

  run_sequencer #(.AW(AW), .MEM_LAT(1), .END_ADDR(3), .WRAP(0), .TIMEOUT(TIMEOUT), .CW(16)) dut0 (
    .Clock(clk), .Resetn(rst_n), .Go(go), .Single(single), .Stop(stop), .Done(done0),
    .Addr(addr0), .Run(run0), .Busy(busy0), .Halted(halted0), .Err(err0), .InstCount(cnt0)
  );

  run_sequencer #(.AW(AW), .MEM_LAT(3), .END_ADDR(6), .WRAP(1), .TIMEOUT(TIMEOUT), .CW(3)) dut1 (
    .Clock(clk), .Resetn(rst_n), .Go(go), .Single(single), .Stop(stop), .Done(done1),
    .Addr(addr1), .Run(run1), .Busy(busy1), .Halted(halted1), .Err(err1), .InstCount(cnt1)
  );

  // Per-configuration reference parameters.
  int m_lat  [2] = '{1, 3};
  int m_end  [2] = '{3, 6};
  bit m_wrap [2] = '{1'b0, 1'b1};
  int m_max  [2] = '{65535, 7};

  // Reference model state.
  int m_mode [2];
  int m_addr [2];
  int m_cnt  [2];
  int m_left [2];
  int m_age  [2];

  // Processor model state.
  int p_age    [2];
  int p_target [2];
  bit d_drv    [2];

  int go_pct, stop_pct, dmode;
  int n_checks, n_errors;
  int k;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_WAIT;
      m_addr[i] = 0;
      m_cnt[i]  = 0;
      m_left[i] = 0;
      m_age[i]  = 0;
    end
  endtask

  task automatic model_step(input int i, input bit dn);
    case (m_mode[i])
      M_WAIT: if (go) begin
        m_mode[i] = M_FETCH;
        m_left[i] = m_lat[i] + 1;
      end
      M_FETCH: begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          m_mode[i] = M_EXEC;
          m_age[i]  = 0;
        end
      end
      M_EXEC: begin
        m_age[i]++;
        if (dn) begin
          if (m_cnt[i] < m_max[i]) m_cnt[i]++;
          if (m_addr[i] == m_end[i] && !m_wrap[i]) begin
            m_mode[i] = M_HALT;
          end else begin
            m_addr[i] = (m_addr[i] == m_end[i]) ? 0 : (m_addr[i] + 1) % (1 << AW);
            if (single || stop) begin
              m_mode[i] = M_WAIT;
            end else begin
              m_mode[i] = M_FETCH;
              m_left[i] = m_lat[i] + 1;
            end
          end
        end else if (m_age[i] == TIMEOUT) begin
          m_mode[i] = M_FAULT;
        end
      end
      M_HALT, M_FAULT: if (go) begin
        m_mode[i] = M_WAIT;
        m_addr[i] = 0;
      end
      default: m_mode[i] = M_WAIT;
    endcase
  endtask

  task automatic cmp(input int i, input logic [31:0] a, input logic r, input logic b,
                     input logic h, input logic e, input logic [31:0] c);
    check($sformatf("d%0d_addr", i),   a, m_addr[i]);
    check($sformatf("d%0d_run", i),    {31'd0, r}, (m_mode[i] == M_EXEC) ? 1 : 0);
    check($sformatf("d%0d_busy", i),   {31'd0, b}, (m_mode[i] == M_FETCH || m_mode[i] == M_EXEC) ? 1 : 0);
    check($sformatf("d%0d_halted", i), {31'd0, h}, (m_mode[i] == M_HALT) ? 1 : 0);
    check($sformatf("d%0d_err", i),    {31'd0, e}, (m_mode[i] == M_FAULT) ? 1 : 0);
    check($sformatf("d%0d_count", i),  c, m_cnt[i]);
  endtask

  task automatic compare_all();
    cmp(0, 32'(addr0), run0, busy0, halted0, err0, 32'(cnt0));
    cmp(1, 32'(addr1), run1, busy1, halted1, err1, 32'(cnt1));
  endtask

  // Done fires on the edge that ends the target-th Run cycle; random noise while Run is low.
  task automatic drive_done(input int i, input logic r);
    if (r) begin
      p_age[i]++;
      if (p_age[i] == 1) begin
        case (dmode)
          0:       p_target[i] = $urandom_range(1, 5);
          1:       p_target[i] = TIMEOUT;
          default: p_target[i] = 1000;
        endcase
      end
      d_drv[i] = (p_age[i] == p_target[i]);
    end else begin
      p_age[i] = 0;
      d_drv[i] = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    drive_done(0, run0);
    drive_done(1, run1);
    done0 = d_drv[0];
    done1 = d_drv[1];
    go    = ($urandom_range(0, 99) < go_pct);
    stop  = ($urandom_range(0, 99) < stop_pct);
    @(posedge clk);
    model_step(0, d_drv[0]);
    model_step(1, d_drv[1]);
    #1;
    compare_all();
  endtask

  task automatic pick_knobs();
    case ($urandom_range(0, 2))
      0:       go_pct = 2;
      1:       go_pct = 20;
      default: go_pct = 90;
    endcase
    case ($urandom_range(0, 2))
      0:       stop_pct = 0;
      1:       stop_pct = 5;
      default: stop_pct = 30;
    endcase
    single = ($urandom_range(0, 2) == 0);
    k = $urandom_range(0, 99);
    dmode = (k < 70) ? 0 : (k < 85) ? 1 : 2;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n  = 1'b0;
    go     = 1'b0;
    single = 1'b0;
    stop   = 1'b0;
    done0  = 1'b0;
    done1  = 1'b0;
    dmode  = 0;
    for (int i = 0; i < 2; i++) begin
      p_age[i] = 0;
      p_target[i] = 0;
      d_drv[i] = 1'b0;
    end
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Opening segment: sparse Go, continuous mode, short Done delays.
    go_pct = 5;
    stop_pct = 0;
    repeat (80) cycle();

    for (int s = 0; s < 36; s++) begin
      pick_knobs();
      repeat (50) cycle();
    end

    // Launch continuously and pull reset low in the middle of an ISSUE cycle.
    go_pct = 100;
    stop_pct = 0;
    single = 1'b0;
    dmode = 2;
    k = 0;
    while (!run0 && k < 100) begin
      cycle();
      k++;
    end
    check("rst_wait_run", {31'd0, run0}, 1);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    go = 1'b0;
    stop = 1'b0;

    for (int s = 0; s < 6; s++) begin
      pick_knobs();
      repeat (50) cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Automatic instruction sequencer that replaces manual memory and processor stepping in the lab processor system.
- Drives the instruction-memory address, waits out the memory read latency, then raises Run to the processor and holds it until Done.
- Advances to the next address and repeats, with continuous, single-step and graceful-stop control.
- Includes a watchdog that traps a processor that never asserts Done.

Parameters:
- AW, 5, instruction-memory address width.
- MEM_LAT, 1, cycles from an Addr change to valid DIN (synchronous ROM); legal range 1..7.
- END_ADDR, 31, last address executed.
- WRAP, 0: 1 = wrap from END_ADDR to 0 and continue; 0 = stop in HALT.
- TIMEOUT, 16, maximum ISSUE cycles without Done before ERROR; legal range 2..255.
- CW, 16, instruction-counter width.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Go  in  1  start or clear request, sampled each cycle (level).
- Single  in  1  1 = execute exactly one instruction per Go.
- Stop  in  1  request to stop after the current instruction completes.
- Done  in  1  processor instruction-complete strobe.
- Addr  out  AW  instruction-memory address.
- Run  out  1  processor Run.
- Busy  out  1  high in FETCH or ISSUE.
- Halted  out  1  high in HALT.
- Err  out  1  high in ERROR.
- InstCount  out  CW  completed instructions; saturates at all-ones.

Behaviour:
- Reset (Resetn=0, asynchronous, takes effect mid-operation): state IDLE, Addr=0, Run=0, Busy=0, Halted=0, Err=0, InstCount=0, internal counters=0.
- All outputs are registered.
- States: IDLE, FETCH, ISSUE, HALT, ERROR.
- IDLE:
  - Go=1 -> FETCH; latency counter loads MEM_LAT.
  - Addr is unchanged.
- FETCH:
  - Addr is held; the latency counter decrements each cycle.
  - When the counter reaches 0 -> ISSUE, with Run=1 registered on the same edge.
  - With MEM_LAT=1: Go sampled at edge k, FETCH during cycle k+1, Run=1 from edge k+2.
- ISSUE:
  - Run=1 and Addr stable throughout; the watchdog counts cycles.
  - Done=1 at an edge: Run<=0; InstCount<=InstCount+1 (saturating); Addr update and next state are decided on that same edge.
  - Addr==END_ADDR: if WRAP=1, Addr<=0; if WRAP=0, Addr is held and the next state is HALT.
  - Otherwise Addr<=Addr+1.
  - Next state: HALT (end, WRAP=0); else IDLE if Single=1 or Stop=1; else FETCH (reload MEM_LAT).
  - Watchdog reaches TIMEOUT with Done=0 -> ERROR; Run<=0, Err<=1, Addr held at the faulting address.
  - Done and watchdog expiry on the same edge: Done wins (normal completion).
- Stop:
  - Sampled only on the Done edge in ISSUE.
  - In FETCH it is ignored; the sequencer continues into ISSUE, so the in-flight instruction always completes.
  - Stop=1 while in IDLE has no effect.
- HALT: Halted=1. Go=1 -> IDLE, Addr<=0, Halted<=0. InstCount is kept.
- ERROR: Err=1 and Run=0. Go=1 -> IDLE, Addr<=0, Err<=0.
- Go while Busy is ignored; Go is not edge-detected. If Go is held high, continuous mode keeps running and single-step re-launches from IDLE on the next cycle.
- Busy = (state==FETCH || state==ISSUE).
- Run is never high outside ISSUE.
- Done seen outside ISSUE is ignored.
- Addr arithmetic is modulo 2^AW; END_ADDR < 2^AW.

Decomposition:
- Shared package:
  - State encoding enum (IDLE=0, FETCH=1, ISSUE=2, HALT=3, ERROR=4), 3 bits.
  - Default parameter constants for AW and MEM_LAT, also used by the memory and top level.
- Natural sub-module: seq_timer. A loadable down-counter with a zero flag, instantiated twice:
  - MEM_LAT wait;
  - TIMEOUT watchdog, loaded with TIMEOUT-1 on ISSUE entry.
- Everything else is in the single FSM module.

Test Plan:
- Reset then Go=1 for 1 cycle (Single=0, MEM_LAT=1, processor model Done 3 cycles after Run rises) -> Run high from the 2nd edge after Go. Addr steps 0,1,2… with Run low for exactly MEM_LAT+1 cycles between instructions. InstCount increments on each Done.
- Single=1 with Go pulsed once -> exactly one instruction; Addr 0->1, InstCount=1, state IDLE, Busy=0. A second Go pulse -> Addr=2.
- END_ADDR=3, WRAP=0, continuous run -> 4 instructions, Halted=1, Addr=3, Run=0. Then Go -> Addr=0, Halted=0. Repeat with WRAP=1 -> Addr sequence 3->0 with no stop.
- Processor model never raises Done, TIMEOUT=16 -> Err=1 and Run=0 after 16 ISSUE cycles, Addr held. Done arriving on exactly the 16th cycle -> no error.
- Stop=1 asserted during FETCH of Addr=2 -> instruction 2 completes, state IDLE, Addr=3. Stop and Done on the same edge -> likewise IDLE.
- Resetn pulsed low mid-ISSUE -> Run, Addr, InstCount go to 0 immediately, without waiting for a clock edge.
